wavetable_voice_scheduler: RTL and testbench

//  Time-shares the single wavetable RAM (12-bit Addr, 2-bit BankSelect, 16-bit DataOut, 1-cycle read

---
 rtl/wavetable_voice_scheduler_if.sv | 46 ++++
 rtl/wavetable_voice_scheduler.sv | 174 +++++++++++++++++
 tb/tb_wavetable_voice_scheduler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wavetable_voice_scheduler_if.sv
// ============================================================================
// wavetable_voice_scheduler_if : sample tick, voice config, wavetable RAM and
// mix signals of the wavetable voice scheduler.  Rev 1.0
// ============================================================================
`default_nettype none

interface wavetable_voice_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int PHASE_W    = 24
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int MIX_W = DATA_W + IDX_W;

  logic                i_sample_tick;
  logic                i_cfg_we;
  logic [IDX_W-1:0]    i_cfg_voice;
  logic [PHASE_W-1:0]  i_cfg_freq;
  logic [1:0]          i_cfg_bank;
  logic                i_cfg_en;
  logic                i_cfg_phase_rst;
  logic [ADDR_W-1:0]   o_ram_addr;
  logic [1:0]          o_ram_bank_sel;
  logic [DATA_W-1:0]   i_ram_data;
  logic [MIX_W-1:0]    o_mix_out;
  logic                o_mix_valid;
  logic                o_busy;
  logic                o_overrun;

  modport slave (
    input  i_sample_tick, i_cfg_we, i_cfg_voice, i_cfg_freq, i_cfg_bank,
           i_cfg_en, i_cfg_phase_rst, i_ram_data,
    output o_ram_addr, o_ram_bank_sel, o_mix_out, o_mix_valid, o_busy,
           o_overrun
  );

  modport master (
    output i_sample_tick, i_cfg_we, i_cfg_voice, i_cfg_freq, i_cfg_bank,
           i_cfg_en, i_cfg_phase_rst, i_ram_data,
    input  o_ram_addr, o_ram_bank_sel, o_mix_out, o_mix_valid, o_busy,
           o_overrun
  );
endinterface

`default_nettype wire

// File: rtl/wavetable_voice_scheduler.sv
// ============================================================================
// wavetable_voice_scheduler : time-shares one wavetable RAM among NUM_VOICES
// phase-accumulator voices and mixes one signed sample per SampleTick. Rev 1.0
// ============================================================================
`default_nettype none

module wavetable_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int PHASE_W    = 24
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_rst_n,
  wavetable_voice_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int MIX_W = DATA_W + IDX_W;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_VOICES - 1);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start;
  logic               w_issue;
  logic [IDX_W-1:0]   w_issue_idx;

  logic [IDX_W-1:0]   r_idx;
  logic               r_rd_en;
  logic [MIX_W-1:0]   r_acc;
  logic [MIX_W-1:0]   w_sample_ext;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [1:0]         r_ram_bank;
  logic [MIX_W-1:0]   r_mix_out;
  logic               r_mix_valid;
  logic               r_overrun;

  logic [PHASE_W-1:0] w_phase [NUM_VOICES];
  logic [1:0]         w_bank  [NUM_VOICES];
  logic               w_en    [NUM_VOICES];
  logic [PHASE_W-1:0] w_issue_phase;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // One voice address goes out per edge: voice 0 on the start edge, then one per ISSUE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_issue_idx = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_sample_tick) begin
          w_state_nxt = ST_ISSUE;
          w_start     = 1'b1;
          w_issue     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (r_idx == c_last_idx) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_issue     = 1'b1;
          w_issue_idx = r_idx + c_idx_one;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_issue_phase = w_phase[w_issue_idx];
  assign w_sample_ext  = {{IDX_W{bus.i_ram_data[DATA_W-1]}}, bus.i_ram_data};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_rd_en     <= 1'b0;
      r_acc       <= '0;
      r_ram_addr  <= '0;
      r_ram_bank  <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      r_overrun   <= bus.i_sample_tick && (r_state != ST_IDLE);

      if (w_start) begin
        r_idx <= '0;
        r_acc <= '0;
      end else if (r_state == ST_ISSUE) begin
        r_idx <= r_idx + c_idx_one;
        r_acc <= r_acc + (r_rd_en ? w_sample_ext : '0);
      end

      // Enable is latched with the address so a later config write cannot change an issued voice.
      if (w_issue) begin
        r_ram_addr <= w_issue_phase[PHASE_W-1 -: ADDR_W];
        r_ram_bank <= w_bank[w_issue_idx];
        r_rd_en    <= w_en[w_issue_idx];
      end

      if (r_state == ST_DRAIN) begin
        r_mix_out   <= r_acc;
        r_mix_valid <= 1'b1;
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_freq;
    logic [1:0]         r_bank;
    logic               r_en;
    logic               w_cfg_hit;
    logic               w_upd;

    assign w_cfg_hit = bus.i_cfg_we && (bus.i_cfg_voice == IDX_W'(v));
    assign w_upd     = w_issue && (w_issue_idx == IDX_W'(v)) && r_en;

    // A same-edge config write sees the old freq/en for the update; a phase reset overrides it.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_phase <= '0;
        r_freq  <= '0;
        r_bank  <= '0;
        r_en    <= 1'b0;
      end else begin
        if (w_cfg_hit) begin
          r_freq <= bus.i_cfg_freq;
          r_bank <= bus.i_cfg_bank;
          r_en   <= bus.i_cfg_en;
        end
        if (w_cfg_hit && bus.i_cfg_phase_rst) begin
          r_phase <= '0;
        end else if (w_upd) begin
          r_phase <= r_phase + r_freq;
        end
      end
    end

    assign w_phase[v] = r_phase;
    assign w_bank[v]  = r_bank;
    assign w_en[v]    = r_en;
  end

  assign bus.o_ram_addr     = r_ram_addr;
  assign bus.o_ram_bank_sel = r_ram_bank;
  assign bus.o_mix_out      = r_mix_out;
  assign bus.o_mix_valid    = r_mix_valid;
  assign bus.o_busy         = (r_state != ST_IDLE);
  assign bus.o_overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_wavetable_voice_scheduler.sv
// ============================================================================
// tb_wavetable_voice_scheduler : random scans against a per-tick voice model,
// with a mix scoreboard drained by an independent monitor. Rev 1.0
// ============================================================================
`default_nettype none

module tb_wavetable_voice_scheduler;
  localparam int NV = 4;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int PW = 24;
  localparam int IW = 2;
  localparam int MW = DW + IW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wavetable_voice_scheduler_if #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .PHASE_W(PW)) bus ();

  wavetable_voice_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .PHASE_W(PW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Wavetable RAM: four banks of 4096 entries, or a forced constant.
  logic [DW-1:0] ram [4*4096];
  logic          force_en = 1'b0;
  logic [DW-1:0] force_val = '0;
  assign bus.i_ram_data = force_en ? force_val : ram[{bus.o_ram_bank_sel, bus.o_ram_addr}];

  // Reference voice state.
  logic [PW-1:0] m_phase [NV];
  logic [PW-1:0] m_freq  [NV];
  logic [1:0]    m_bank  [NV];
  bit            m_en    [NV];
  logic [AW-1:0] e_addr  [NV];
  logic [1:0]    e_bank  [NV];
  logic [MW-1:0] exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0; m_freq[v] = '0; m_bank[v] = '0; m_en[v] = 1'b0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_cfg(input logic [IW-1:0] v, input logic [PW-1:0] f,
                                    input logic [1:0] b, input bit e, input bit p);
    m_freq[v] = f; m_bank[v] = b; m_en[v] = e;
    if (p) m_phase[v] = '0;
  endfunction

  // One tick: every voice reads at its current phase, enabled ones sum and advance.
  function automatic void model_scan();
    int sum;
    logic [DW-1:0] d;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      e_addr[v] = m_phase[v][PW-1 -: AW];
      e_bank[v] = m_bank[v];
      if (m_en[v]) begin
        d = force_en ? force_val : ram[{m_bank[v], e_addr[v]}];
        sum += int'($signed(d));
        m_phase[v] = m_phase[v] + m_freq[v];
      end
    end
    exp_q.push_back(sum[MW-1:0]);
  endfunction

  always @(negedge clk) begin
    if (bus.o_mix_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mix_valid_unexpected: got MixValid=1 expected none at %0t", $time);
      end else begin
        logic [MW-1:0] e;
        e = exp_q.pop_front();
        chk("mix_out", 32'(bus.o_mix_out), 32'(e));
      end
    end
  end

  task automatic set_cfg(input logic [IW-1:0] v, input logic [PW-1:0] f,
                         input logic [1:0] b, input bit e, input bit p);
    bus.i_cfg_we = 1'b1; bus.i_cfg_voice = v; bus.i_cfg_freq = f;
    bus.i_cfg_bank = b; bus.i_cfg_en = e; bus.i_cfg_phase_rst = p;
  endtask

  task automatic cfg_write(input logic [IW-1:0] v, input logic [PW-1:0] f,
                           input logic [1:0] b, input bit e, input bit p);
    set_cfg(v, f, b, e, p);
    @(negedge clk);
    bus.i_cfg_we = 1'b0;
    model_cfg(v, f, b, e, p);
  endtask

  // Starts a scan at the current negedge; returns at the negedge where MixValid is seen.
  // ovr_at > 0 injects a tick sampled at edge E<ovr_at>; cfg_slot >= 0 writes voice cv at E<cfg_slot>.
  task automatic do_scan(input int ovr_at, input int cfg_slot, input logic [IW-1:0] cv,
                         input logic [PW-1:0] cf, input logic [1:0] cb, input bit ce, input bit cp);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 1'b0;
    model_scan();
    bus.i_sample_tick = 1'b1;
    if (cfg_slot == 0) set_cfg(cv, cf, cb, ce, cp);
    while (cnt < 20 && !seen) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        bus.i_sample_tick = 1'b0;
        chk("busy_after_tick", 32'(bus.o_busy), 32'(1));
        chk("overrun_on_accept", 32'(bus.o_overrun), 32'(0));
      end
      if (cfg_slot >= 0 && cnt == cfg_slot + 1) begin
        bus.i_cfg_we = 1'b0;
        model_cfg(cv, cf, cb, ce, cp);
      end
      if (cfg_slot > 0 && cnt == cfg_slot) set_cfg(cv, cf, cb, ce, cp);
      if (ovr_at > 0 && cnt == ovr_at) bus.i_sample_tick = 1'b1;
      if (ovr_at > 0 && cnt == ovr_at + 1) begin
        bus.i_sample_tick = 1'b0;
        chk("overrun_pulse", 32'(bus.o_overrun), 32'(1));
      end
      if (ovr_at > 0 && cnt == ovr_at + 2) chk("overrun_width", 32'(bus.o_overrun), 32'(0));
      if (cnt <= NV) begin
        chk("ram_addr", 32'(bus.o_ram_addr), 32'(e_addr[cnt-1]));
        chk("ram_bank", 32'(bus.o_ram_bank_sel), 32'(e_bank[cnt-1]));
      end
      if (bus.o_mix_valid === 1'b1) seen = 1'b1;
    end
    chk("mix_latency_negedges", 32'(cnt), 32'(NV + 2));
    chk("busy_in_mixvalid", 32'(bus.o_busy), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_cfg;
    int gap;
    int slot;
    rst_n = 1'b0;
    bus.i_sample_tick = 1'b0;
    bus.i_cfg_we = 1'b0; bus.i_cfg_voice = '0; bus.i_cfg_freq = '0;
    bus.i_cfg_bank = '0; bus.i_cfg_en = 1'b0; bus.i_cfg_phase_rst = 1'b0;
    for (int i = 0; i < 4*4096; i++) ram[i] = DW'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ram_addr",  32'(bus.o_ram_addr), 32'(0));
    chk("rst_ram_bank",  32'(bus.o_ram_bank_sel), 32'(0));
    chk("rst_mix_out",   32'(bus.o_mix_out), 32'(0));
    chk("rst_mix_valid", 32'(bus.o_mix_valid), 32'(0));
    chk("rst_busy",      32'(bus.o_busy), 32'(0));
    chk("rst_overrun",   32'(bus.o_overrun), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // All voices disabled: zero mix, phases stay at zero.
    do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);

    // Single voice stepping one table entry per tick, back-to-back ticks.
    cfg_write(2'd0, 24'h001000, 2'd0, 1'b1, 1'b0);
    repeat (3) do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);

    // Full-scale positive and negative mixes.
    for (int v = 1; v < NV; v++) cfg_write(IW'(v), PW'($urandom), 2'(v), 1'b1, 1'b0);
    force_en = 1'b1;
    force_val = 16'h7FFF;
    do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);
    force_val = 16'h8000;
    do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);
    force_en = 1'b0;

    // Phase wrap: 0 -> FFFFFF -> FFFFFE -> FFFFFD, then +3 wraps to 0.
    cfg_write(2'd0, 24'h000000, 2'd0, 1'b0, 1'b0);
    cfg_write(2'd2, 24'h000000, 2'd0, 1'b0, 1'b0);
    cfg_write(2'd3, 24'h000000, 2'd0, 1'b0, 1'b0);
    cfg_write(2'd1, 24'hFFFFFF, 2'd1, 1'b1, 1'b1);
    repeat (3) do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);
    cfg_write(2'd1, 24'h000003, 2'd1, 1'b1, 1'b0);
    repeat (2) do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);

    // Overrun during ISSUE, then a tick in the MixValid cycle.
    do_scan(2, -1, '0, '0, '0, 1'b0, 1'b0);
    do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);

    // Same-edge config on the voice being issued: phase reset wins, otherwise old freq applies.
    cfg_write(2'd2, 24'h234567, 2'd3, 1'b1, 1'b0);
    do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);
    do_scan(0, 2, 2'd2, 24'h0ABCDE, 2'd2, 1'b1, 1'b1);
    do_scan(0, 2, 2'd2, 24'h111111, 2'd1, 1'b1, 1'b0);
    do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);

    // Reset in the middle of ISSUE aborts the scan.
    @(negedge clk);
    bus.i_sample_tick = 1'b1;
    @(negedge clk);
    bus.i_sample_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_mix_valid", 32'(bus.o_mix_valid), 32'(0));
      @(negedge clk);
    end
    chk("abort_mix_out",  32'(bus.o_mix_out), 32'(0));
    chk("abort_ram_addr", 32'(bus.o_ram_addr), 32'(0));
    chk("abort_busy",     32'(bus.o_busy), 32'(0));
    cfg_write(2'd1, 24'h0F0F0F, 2'd2, 1'b1, 1'b0);
    do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);

    // Randomised config and tick spacing.
    for (int it = 0; it < 30; it++) begin
      n_cfg = $urandom_range(0, 2);
      for (int j = 0; j < n_cfg; j++)
        cfg_write(IW'($urandom_range(0, NV-1)), PW'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        slot = $urandom_range(0, NV-1);
        do_scan(0, slot, IW'(slot), PW'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 1));
      end else begin
        do_scan(0, -1, '0, '0, '0, 1'b0, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
